// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell driven LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic [WIDTH-1:0]   s_next_c;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               fa_sum_c;
    logic               fa_cout_c;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum_c),
        .cout (fa_cout_c)
    );

    // Sum bits are written in place by bit index so no shifted-out bit is left dangling.
    always_comb begin
        s_next_c      = s_sh;
        s_next_c[cnt] = fa_sum_c;
    end

    // Sequencer; result registers only move on the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_sh  <= b;
                        carry <= cin;
`endif
                        s_sh  <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_cout_c;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next_c;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= s_next_c;
                        cout  <= fa_cout_c;
                        ovf   <= carry ^ fa_cout_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); covers the sub port
// when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;
    localparam int unsigned WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub   = 1'b0;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] sum;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] prev_sum = '0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted operation; operands are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int   n;
        logic seen;
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0; a = ~av; b = ~bv; cin = ~cv;
        check({tag, ".busy"},  busy,  1);
        check({tag, ".ready"}, ready, 0);
        check({tag, ".hold"},  sum,   prev_sum);
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                tick();
                n = i;
                if (done) seen = 1'b1;
            end
        end
        check({tag, ".lat"},  n,    WIDTH);
        check({tag, ".sum"},  sum,  es);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".ovf"},  ovf,  eo);
        prev_sum = es;
        tick();
        check({tag, ".done_low"}, done,  0);
        check({tag, ".ready_up"}, ready, 1);
    endtask

    initial begin
        int nd;
        int d[4];

        // reset state, during and after reset
        tick();
        tick();
        check("rst.ready", ready, 1);
        check("rst.busy",  busy,  0);
        check("rst.done",  done,  0);
        check("rst.sum",   sum,   8'h00);
        check("rst.cout",  cout,  0);
        check("rst.ovf",   ovf,   0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle.ready", ready, 1);
        check("idle.busy",  busy,  0);
        check("idle.sum",   sum,   8'h00);

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("add0f_cin", 8'h0F, 8'h0F, 1'b1, 8'h1F, 1'b0, 1'b0);
        run_op("addff_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start during RUN is ignored and not queued
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) nd++;
        end
        check("ign.done_count", nd,   1);
        check("ign.sum",        sum,  8'h7F);
        check("ign.busy",       busy, 0);
        prev_sum = 8'h7F;

        // start held high: back-to-back every WIDTH+2 cycles
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        nd = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                if (nd < 4) d[nd] = i;
                nd++;
            end
        end
        start = 1'b0;
        check("held.count", nd, 4);
        check("held.first", d[0], WIDTH + 1);
        check("held.gap1",  d[1] - d[0], WIDTH + 2);
        check("held.gap2",  d[2] - d[1], WIDTH + 2);
        check("held.sum",   sum, 8'h03);
        tick();
        tick();
        check("held.idle_busy",  busy,  0);
        check("held.idle_ready", ready, 1);
        prev_sum = 8'h03;

        // async reset in RUN cycle 4 aborts the operation
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort.ready", ready, 1);
        check("abort.busy",  busy,  0);
        check("abort.done",  done,  0);
        check("abort.sum",   sum,   8'h00);
        check("abort.cout",  cout,  0);
        check("abort.ovf",   ovf,   0);
        tick();
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) nd++;
        end
        check("abort.no_done", nd,    0);
        check("abort.ready2",  ready, 1);
        prev_sum = 8'h00;
        run_op("fresh", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        sub = 1'b0;
        run_op("sub0_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
